// File: rtl/rtc_calendar_counter.sv
// rtc_calendar_counter: synchronous year/month/day/hour/minute/second counter with prescaler, validated load and alarm
// clk, reset (async, active-low); start/stop run control; load + ld_* parallel load;
// al_en/al_* alarm time; year..second current time; running; sec_tick, load_err, year_wrap, alarm one-cycle pulses
module rtc_calendar_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int YEAR_W = 7,
  parameter int LEAP_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              load,
  input  logic [YEAR_W-1:0] ld_year,
  input  logic [3:0]        ld_month,
  input  logic [4:0]        ld_day,
  input  logic [4:0]        ld_hour,
  input  logic [5:0]        ld_minute,
  input  logic [5:0]        ld_second,
  input  logic              al_en,
  input  logic [4:0]        al_hour,
  input  logic [5:0]        al_minute,
  input  logic [5:0]        al_second,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [4:0]        hour,
  output logic [5:0]        minute,
  output logic [5:0]        second,
  output logic              running,
  output logic              sec_tick,
  output logic              load_err,
  output logic              year_wrap,
  output logic              alarm
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_TOP = PW'(TICK_DIV - 1);
  logic [PW-1:0] presc;
  logic match_q;
  logic inc, ld_ok, s_c, m_c, h_c, d_c, mo_c, y_c, match;
  // Year offsets share the base year's leap phase because the base is a multiple of 4.
  function automatic logic [4:0] dim(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    return (m == 4'd2) ? ((LEAP_EN != 0 && y[1:0] == 2'd0) ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  always_comb begin
    inc = running && presc == P_TOP;
    ld_ok = ld_month >= 4'd1 && ld_month <= 4'd12 && ld_day >= 5'd1 &&
            ld_day <= dim(ld_month, ld_year) && ld_hour <= 5'd23 &&
            ld_minute <= 6'd59 && ld_second <= 6'd59;
    s_c = second == 6'd59;
    m_c = s_c && minute == 6'd59;
    h_c = m_c && hour == 5'd23;
    d_c = h_c && day == dim(month, year);
    mo_c = d_c && month == 4'd12;
    y_c = mo_c && year == {YEAR_W{1'b1}};
    match = al_en && hour == al_hour && minute == al_minute && second == al_second;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      year <= '0;
      month <= 4'd1;
      day <= 5'd1;
      hour <= '0;
      minute <= '0;
      second <= '0;
      running <= 1'b0;
      presc <= '0;
      sec_tick <= 1'b0;
      load_err <= 1'b0;
      year_wrap <= 1'b0;
      alarm <= 1'b0;
      match_q <= 1'b0;
    end else begin
      running <= stop ? 1'b0 : start ? 1'b1 : running;
      sec_tick <= inc && !load;
      load_err <= load && !ld_ok;
      year_wrap <= inc && !load && y_c;
      match_q <= match;
      alarm <= match && !match_q;
      // A load strobe, valid or not, swallows any increment due this cycle.
      if (load) begin
        if (ld_ok) begin
          year <= ld_year;
          month <= ld_month;
          day <= ld_day;
          hour <= ld_hour;
          minute <= ld_minute;
          second <= ld_second;
          presc <= '0;
        end
      end else begin
        if (running) presc <= inc ? '0 : presc + PW'(1);
        if (inc) begin
          second <= s_c ? 6'd0 : second + 6'd1;
          if (s_c) minute <= m_c ? 6'd0 : minute + 6'd1;
          if (m_c) hour <= h_c ? 5'd0 : hour + 5'd1;
          if (h_c) day <= d_c ? 5'd1 : day + 5'd1;
          if (d_c) month <= mo_c ? 4'd1 : month + 4'd1;
          if (mo_c) year <= year + YEAR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_rtc_calendar_counter.sv
// tb_rtc_calendar_counter: scoreboard bench for rtc_calendar_counter with TICK_DIV=4
module tb_rtc_calendar_counter;
  localparam int TD = 4;
  localparam int YW = 7;
  logic clk = 0, reset = 0, start = 0, stop = 0, load = 0, al_en = 0;
  logic [YW-1:0] ld_year = '0;
  logic [3:0] ld_month = 4'd1;
  logic [4:0] ld_day = 5'd1, ld_hour = '0, al_hour = '0;
  logic [5:0] ld_minute = '0, ld_second = '0, al_minute = '0, al_second = '0;
  logic [YW-1:0] year;
  logic [3:0] month;
  logic [4:0] day, hour;
  logic [5:0] minute, second;
  logic running, sec_tick, load_err, year_wrap, alarm;
  logic [32:0] cur, got;
  logic [32:0] exp_q[$];
  int vectors = 0, errors = 0;
  int cal_ld[9][6] = '{'{3,2,28,23,59,59}, '{4,2,28,23,59,59}, '{4,2,29,23,59,59},
                       '{5,2,28,23,59,59}, '{127,12,31,23,59,59}, '{10,4,30,23,59,59},
                       '{10,1,31,12,59,59}, '{10,11,30,23,59,59}, '{10,1,1,0,0,59}};
  int cal_ex[9][6] = '{'{3,3,1,0,0,0}, '{4,2,29,0,0,0}, '{4,3,1,0,0,0},
                       '{5,3,1,0,0,0}, '{0,1,1,0,0,0}, '{10,5,1,0,0,0},
                       '{10,1,31,13,0,0}, '{10,12,1,0,0,0}, '{10,1,1,0,1,0}};
  logic cal_wrap[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
  int bad_ld[9][6] = '{'{9,4,31,1,1,1}, '{9,13,1,0,0,0}, '{9,0,1,0,0,0},
                       '{9,5,0,0,0,0}, '{9,5,1,24,0,0}, '{9,5,1,0,60,0},
                       '{9,5,1,0,0,60}, '{1,2,29,0,0,0}, '{8,2,30,0,0,0}};
  assign cur = {year, month, day, hour, minute, second};
  always #5 clk = ~clk;
  rtc_calendar_counter #(.TICK_DIV(TD), .YEAR_W(YW), .LEAP_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .ld_year(ld_year), .ld_month(ld_month), .ld_day(ld_day), .ld_hour(ld_hour),
    .ld_minute(ld_minute), .ld_second(ld_second), .al_en(al_en), .al_hour(al_hour),
    .al_minute(al_minute), .al_second(al_second), .year(year), .month(month),
    .day(day), .hour(hour), .minute(minute), .second(second), .running(running),
    .sec_tick(sec_tick), .load_err(load_err), .year_wrap(year_wrap), .alarm(alarm)
  );
  function automatic logic [32:0] pk(input int y, input int mo, input int d, input int h, input int mi, input int s);
    return {YW'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input int y, input int mo, input int d, input int h, input int mi, input int s);
    ld_year = YW'(y);
    ld_month = 4'(mo);
    ld_day = 5'(d);
    ld_hour = 5'(h);
    ld_minute = 6'(mi);
    ld_second = 6'(s);
    load = 1;
    step();
    load = 0;
  endtask
  task automatic wait_tick(output int n);
    bit found = 0;
    n = 0;
    while (!found && n < 16) begin
      step();
      n++;
      if (sec_tick) found = 1;
    end
    if (!found) n = -1;
  endtask
  task automatic test_reset();
    reset = 0;
    step();
    step();
    vectors++;
    if (cur !== pk(0,1,1,0,0,0)) begin errors++; $display("FAIL reset_state got %h want %h", cur, pk(0,1,1,0,0,0)); end
    vectors++;
    if ({running, sec_tick, load_err, year_wrap, alarm} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {running, sec_tick, load_err, year_wrap, alarm});
    end
    reset = 1;
    step();
  endtask
  task automatic test_start_tick();
    int n;
    start = 1;
    step();
    start = 0;
    vectors++;
    if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b want 1", running); end
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(pk(0,1,1,0,0,k));
      wait_tick(n);
      got = exp_q.pop_front();
      vectors++;
      if (n != TD) begin errors++; $display("FAIL tick_gap got %0d want %0d", n, TD); end
      vectors++;
      if (cur !== got) begin errors++; $display("FAIL tick_state got %h want %h", cur, got); end
    end
  endtask
  task automatic test_calendar();
    int n;
    for (int i = 0; i < 9; i++) begin
      do_load(cal_ld[i][0], cal_ld[i][1], cal_ld[i][2], cal_ld[i][3], cal_ld[i][4], cal_ld[i][5]);
      exp_q.push_back(pk(cal_ex[i][0], cal_ex[i][1], cal_ex[i][2], cal_ex[i][3], cal_ex[i][4], cal_ex[i][5]));
      wait_tick(n);
      got = exp_q.pop_front();
      vectors++;
      if (n != TD) begin errors++; $display("FAIL cal_gap[%0d] got %0d want %0d", i, n, TD); end
      vectors++;
      if (cur !== got) begin errors++; $display("FAIL cal_state[%0d] got %h want %h", i, cur, got); end
      vectors++;
      if (year_wrap !== cal_wrap[i]) begin errors++; $display("FAIL cal_wrap[%0d] got %b want %b", i, year_wrap, cal_wrap[i]); end
      step();
      vectors++;
      if (year_wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse[%0d] got %b want 0", i, year_wrap); end
    end
  endtask
  task automatic test_load_err();
    stop = 1;
    step();
    stop = 0;
    do_load(9,6,30,12,0,0);
    vectors++;
    if (cur !== pk(9,6,30,12,0,0) || load_err !== 1'b0) begin
      errors++; $display("FAIL load_valid got %h err %b want %h err 0", cur, load_err, pk(9,6,30,12,0,0));
    end
    for (int i = 0; i < 9; i++) begin
      do_load(bad_ld[i][0], bad_ld[i][1], bad_ld[i][2], bad_ld[i][3], bad_ld[i][4], bad_ld[i][5]);
      vectors++;
      if (load_err !== 1'b1) begin errors++; $display("FAIL load_err[%0d] got %b want 1", i, load_err); end
      vectors++;
      if (cur !== pk(9,6,30,12,0,0)) begin errors++; $display("FAIL load_hold[%0d] got %h want %h", i, cur, pk(9,6,30,12,0,0)); end
      step();
      vectors++;
      if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_pulse[%0d] got %b want 0", i, load_err); end
    end
    do_load(8,2,29,23,59,59);
    vectors++;
    if (cur !== pk(8,2,29,23,59,59) || load_err !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL load_leap got %h err %b run %b want %h err 0 run 0", cur, load_err, running, pk(8,2,29,23,59,59));
    end
  endtask
  task automatic test_run_ctl();
    int n;
    int bad = 0;
    start = 1;
    stop = 1;
    step();
    start = 0;
    stop = 0;
    vectors++;
    if (running !== 1'b0) begin errors++; $display("FAIL stop_wins_idle got %b want 0", running); end
    start = 1;
    step();
    start = 0;
    exp_q.push_back(pk(8,3,1,0,0,0));
    wait_tick(n);
    got = exp_q.pop_front();
    vectors++;
    if (n != TD || cur !== got) begin errors++; $display("FAIL leap_tick gap %0d state %h want gap %0d state %h", n, cur, TD, got); end
    step();
    stop = 1;
    step();
    stop = 0;
    vectors++;
    if (running !== 1'b0) begin errors++; $display("FAIL stop_mid got %b want 0", running); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (sec_tick || cur !== got) bad++;
    end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL stopped_hold got %0d changes want 0", bad); end
    start = 1;
    step();
    start = 0;
    exp_q.push_back(pk(8,3,1,0,0,1));
    wait_tick(n);
    got = exp_q.pop_front();
    vectors++;
    if (n != 2) begin errors++; $display("FAIL resume_gap got %0d want 2", n); end
    vectors++;
    if (cur !== got) begin errors++; $display("FAIL resume_state got %h want %h", cur, got); end
    start = 1;
    stop = 1;
    step();
    start = 0;
    stop = 0;
    vectors++;
    if (running !== 1'b0) begin errors++; $display("FAIL stop_wins_run got %b want 0", running); end
  endtask
  task automatic test_alarm();
    int e = 0, e5 = -1, ea = -1, cnt = 0;
    al_hour = 5'd0;
    al_minute = 6'd0;
    al_second = 6'd5;
    al_en = 1;
    do_load(0,1,1,0,0,2);
    start = 1;
    step();
    start = 0;
    while (e < 60 && !(e5 >= 0 && e >= e5 + 11)) begin
      step();
      e++;
      if (alarm) begin cnt++; ea = e; end
      if (e5 >= 0 && e == e5 + 1) stop = 0;
      if (second == 6'd5 && e5 < 0) begin e5 = e; stop = 1; end
    end
    stop = 0;
    vectors++;
    if (e5 < 0) begin errors++; $display("FAIL alarm_reach second got %0d want 5", second); end
    vectors++;
    if (cnt != 1) begin errors++; $display("FAIL alarm_count got %0d want 1", cnt); end
    vectors++;
    if (ea != e5 + 1) begin errors++; $display("FAIL alarm_timing got edge %0d want %0d", ea, e5 + 1); end
    do_load(0,1,1,0,0,7);
    step();
    do_load(0,1,1,0,0,5);
    vectors++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_load_early got %b want 0", alarm); end
    step();
    vectors++;
    if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_on_load got %b want 1", alarm); end
    cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); if (alarm) cnt++; end
    vectors++;
    if (cnt != 0) begin errors++; $display("FAIL alarm_refire got %0d want 0", cnt); end
    al_en = 0;
    do_load(0,1,1,0,0,7);
    do_load(0,1,1,0,0,5);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); if (alarm) cnt++; end
    vectors++;
    if (cnt != 0) begin errors++; $display("FAIL alarm_disabled got %0d want 0", cnt); end
  endtask
  task automatic test_async_reset();
    int n;
    start = 1;
    step();
    start = 0;
    step();
    step();
    #3;
    reset = 0;
    #1;
    vectors++;
    if (cur !== pk(0,1,1,0,0,0)) begin errors++; $display("FAIL async_reset_state got %h want %h", cur, pk(0,1,1,0,0,0)); end
    vectors++;
    if ({running, sec_tick, load_err, year_wrap, alarm} !== 5'b0) begin
      errors++; $display("FAIL async_reset_flags got %b want 00000", {running, sec_tick, load_err, year_wrap, alarm});
    end
    step();
    reset = 1;
    start = 1;
    step();
    start = 0;
    exp_q.push_back(pk(0,1,1,0,0,1));
    wait_tick(n);
    got = exp_q.pop_front();
    vectors++;
    if (n != TD || cur !== got) begin errors++; $display("FAIL post_reset_tick gap %0d state %h want gap %0d state %h", n, cur, TD, got); end
  endtask
  initial begin
    test_reset();
    test_start_tick();
    test_calendar();
    test_load_err();
    test_run_ctl();
    test_alarm();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors %0d", vectors);
    $fatal(1);
  end
endmodule
